// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath:
// instruction fields and ALU flag in, every enable/select and debug state out.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;
    logic       instret;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, instret, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen, instret, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath, one instruction at a time.
module mc_controller (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state_q, state_d;
    logic   pcwrite, irwrite_raw, regwrite_raw, memwrite_raw, instret_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = FETCH;
        pcwrite         = 1'b0;
        irwrite_raw     = 1'b0;
        regwrite_raw    = 1'b0;
        memwrite_raw    = 1'b0;
        instret_raw     = 1'b0;
        bus.iord        = 1'b0;
        bus.regdst      = 1'b0;
        bus.memtoreg    = 1'b0;
        bus.alusrca     = 1'b0;
        bus.alusrcb     = 2'b00;
        bus.pcsrc       = 2'b00;
        bus.alucontrol  = 3'b000;
        case (state_q)
            FETCH: begin
                state_d        = DECODE;
                irwrite_raw    = 1'b1;
                pcwrite        = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = ALU_ADD;
            end
            DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_BNE:       state_d = BNEEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        // unknown opcode retires here as a nop
                        state_d     = FETCH;
                        instret_raw = 1'b1;
                    end
                endcase
            end
            MEMADR, ADDIEX: begin
                if (state_q == ADDIEX) state_d = ADDIWB;
                else                   state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = ALU_ADD;
            end
            MEMRD: begin
                state_d  = MEMWB;
                bus.iord = 1'b1;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                regwrite_raw = 1'b1;
                instret_raw  = 1'b1;
            end
            MEMWR: begin
                bus.iord     = 1'b1;
                memwrite_raw = 1'b1;
                instret_raw  = 1'b1;
            end
            RTYPEEX: begin
                state_d     = RTYPEWB;
                bus.alusrca = 1'b1;
                case (bus.funct)
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default:   bus.alucontrol = ALU_ADD;
                endcase
            end
            RTYPEWB: begin
                bus.regdst   = 1'b1;
                regwrite_raw = 1'b1;
                instret_raw  = 1'b1;
            end
            ADDIWB: begin
                regwrite_raw = 1'b1;
                instret_raw  = 1'b1;
            end
            BEQEX, BNEEX: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = ALU_SUB;
                bus.pcsrc      = 2'b01;
                instret_raw    = 1'b1;
            end
            JEX: begin
                bus.pcsrc   = 2'b10;
                pcwrite     = 1'b1;
                instret_raw = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // reset masks every architectural write so an abandoned instruction has no effect
    assign bus.pcen     = ~reset & (pcwrite | ((state_q == BEQEX) & bus.zero)
                                            | ((state_q == BNEEX) & ~bus.zero));
    assign bus.irwrite  = ~reset & irwrite_raw;
    assign bus.regwrite = ~reset & regwrite_raw;
    assign bus.memwrite = ~reset & memwrite_raw;
    assign bus.instret  = ~reset & instret_raw;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: an instruction-level model
// yields the state walk per opcode and the per-state control table of the ISA.
module tb_mc_controller;
    typedef int iq_t[$];

    logic clk = 1'b0;
    logic reset;
    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen,instret}
    function automatic logic [16:0] observed();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.pcen, bus.instret};
    endfunction

    function automatic iq_t seq_of(input logic [5:0] op);
        iq_t q;
        case (op)
            6'b100011: q = '{0, 1, 2, 3, 4};
            6'b101011: q = '{0, 1, 2, 5};
            6'b000000: q = '{0, 1, 6, 7};
            6'b000100: q = '{0, 1, 8};
            6'b000101: q = '{0, 1, 12};
            6'b001000: q = '{0, 1, 9, 10};
            6'b000010: q = '{0, 1, 11};
            default:   q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic [16:0] expected(input int s, input logic [5:0] f, input logic z,
                                             input logic unk, input logic rst);
        logic iord = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, asa = 0, pw = 0, br = 0, ir = 0;
        logic [1:0] asb = 2'b00, pcs = 2'b00;
        logic [2:0] alu = 3'b000;
        case (s)
            0:  begin irw = 1; pw = 1; asb = 2'b01; alu = 3'b010; end
            1:  begin asb = 2'b11; alu = 3'b010; ir = unk; end
            2, 9: begin asa = 1; asb = 2'b10; alu = 3'b010; end
            3:  iord = 1;
            4:  begin mtr = 1; rw = 1; ir = 1; end
            5:  begin iord = 1; mw = 1; ir = 1; end
            6:  begin asa = 1; alu = alu_of_funct(f); end
            7:  begin rd = 1; rw = 1; ir = 1; end
            8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; ir = 1; br = z; end
            12: begin asa = 1; alu = 3'b110; pcs = 2'b01; ir = 1; br = ~z; end
            10: begin rw = 1; ir = 1; end
            11: begin pcs = 2'b10; pw = 1; ir = 1; end
            default: ;
        endcase
        if (rst) begin
            irw = 0; rw = 0; mw = 0; pw = 0; br = 0; ir = 0;
        end
        return {iord, mw, irw, rd, mtr, rw, asa, asb, pcs, alu, pw | br, ir};
    endfunction

    // Called just after a rising edge with the FSM in FETCH; zmode < 0 randomizes zero.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                             input int reset_at);
        iq_t q = seq_of(op);
        logic unk = (q.size() == 2);
        int pulses = 0;
        logic z;
        bit aborted = 0;
        bus.op    = op;
        bus.funct = f;
        for (int i = 0; i < q.size(); i++) begin
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.zero = z;
            if (i == reset_at) reset = 1'b1;
            @(negedge clk);
            check($sformatf("op%b step%0d state", op, i), 32'(bus.state), 32'(q[i]));
            check($sformatf("op%b st%0d ctl", op, q[i]), 32'(observed()),
                  32'(expected(q[i], f, z, unk, reset)));
            pulses += int'(bus.instret);
            @(posedge clk);
            #1;
            if (reset) begin
                reset   = 1'b0;
                aborted = 1;
                break;
            end
        end
        if (!aborted) check($sformatf("op%b instret pulses", op), 32'(pulses), 32'd1);
    endtask

    logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000101, 6'b001000, 6'b000010};
    logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] rop, rf;
        reset     = 1'b1;
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("reset state", 32'(bus.state), 32'd0);
            check("reset writes", 32'({bus.memwrite, bus.regwrite, bus.pcen, bus.irwrite, bus.instret}),
                  32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(6'b100011, 6'b000000, -1, -1);
        run_instr(6'b101011, 6'b000000, -1, -1);
        run_instr(6'b000000, 6'b101010, -1, -1);
        run_instr(6'b000000, 6'b111111, -1, -1);
        run_instr(6'b000100, 6'b000000, 1, -1);
        run_instr(6'b000100, 6'b000000, 0, -1);
        run_instr(6'b000101, 6'b000000, 0, -1);
        run_instr(6'b000101, 6'b000000, 1, -1);
        run_instr(6'b001000, 6'b000000, -1, -1);
        run_instr(6'b000010, 6'b000000, -1, -1);
        run_instr(6'b111111, 6'b000000, -1, -1);
        run_instr(6'b100011, 6'b000000, -1, 3);
        run_instr(6'b101011, 6'b000000, -1, -1);

        for (int n = 0; n < 300; n++) begin
            rop = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            rf  = ($urandom_range(0, 5) == 5) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            run_instr(rop, rf, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control unit for the multicycle MIPS core.
- Moore FSM that sequences the shared datapath one instruction at a time: fetch, decode, execute, memory and writeback.
- Drives every enable and mux select of the unified instruction/data memory datapath; `top` instantiates it next to the datapath.
- Also emits a one-cycle retire pulse per completed instruction for bench and performance use.

Parameters:
- None. Opcode, funct and state encodings are fixed as listed below.

Ports:
- clk  in  1  system clock, rising-edge active
- reset  in  1  synchronous, active-high; one clock, reset sampled on the rising edge of clk
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag from the datapath
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- regdst  out  1  destination register: 0 = rt, 1 = rd
- memtoreg  out  1  writeback source: 0 = ALUOut, 1 = Data register
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A: 0 = PC, 1 = A register
- alusrcb  out  2  ALU B: 00 = B register, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU operation
- pcen  out  1  PC load enable
- instret  out  1  high in the final cycle of each instruction
- state  out  4  current state, for debug

Behaviour:
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, bne 000101, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12. Encodings 13-15 return to FETCH.
- Reset: state <= FETCH on any rising edge with reset = 1. While reset = 1, pcen, irwrite, regwrite and memwrite are forced 0 combinationally. A reset mid-instruction abandons the instruction with no further writes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR for lw/sw; RTYPEEX for R-type; BEQEX for beq; BNEEX for bne; ADDIEX for addi; JEX for j; FETCH for any other opcode (treated as a nop).
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB; RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX, JEX -> FETCH.
- Outputs per state (unlisted signals are 0):
  - FETCH: irwrite = 1, pcwrite = 1, alusrcb = 01, alu add.
  - DECODE: alusrcb = 11, alu add.
  - MEMADR / ADDIEX: alusrca = 1, alusrcb = 10, alu add.
  - MEMRD: iord = 1.
  - MEMWB: memtoreg = 1, regwrite = 1.
  - MEMWR: iord = 1, memwrite = 1.
  - RTYPEEX: alusrca = 1, alusrcb = 00, alu from funct.
  - RTYPEWB: regdst = 1, regwrite = 1.
  - ADDIWB: regwrite = 1.
  - BEQEX / BNEEX: alusrca = 1, alu sub, pcsrc = 01.
  - JEX: pcsrc = 10, pcwrite = 1.
- pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero). This is combinational on zero in the same cycle.
- ALU codes: add 010, sub 110. Funct decode in RTYPEEX: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010, and writeback still occurs.
- instret = 1 in MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, BNEEX and JEX, and in DECODE when the opcode is unknown. instret is 0 during reset.
- Cycle counts: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, unknown 2.
- Outputs depend on state only, except pcen (zero), alucontrol (funct in RTYPEEX) and instret (op in DECODE).

Test Plan:
- Reset held 2 cycles, op = 100011 -> state = 0, memwrite = regwrite = pcen = 0 during reset; FETCH outputs appear after reset deasserts.
- lw (op 100011) -> states 0,1,2,3,4; regwrite and memtoreg = 1 only in the 5th cycle; instret pulses once.
- sw (op 101011) -> states 0,1,2,5; memwrite = 1 and iord = 1 exactly in cycle 4; regwrite never asserted.
- R-type funct 101010 -> alucontrol = 111 in RTYPEEX; regdst = 1, regwrite = 1 in RTYPEWB; funct 111111 -> alucontrol = 010.
- beq with zero = 1 -> pcen = 1 in BEQEX; beq with zero = 0 -> pcen = 0; bne with zero = 0 -> pcen = 1; all three return to FETCH after 3 cycles.
- op = 111111 -> DECODE -> FETCH with instret = 1 and no writes; reset asserted in MEMRD -> state = 0 next edge and regwrite never asserted.
